// File: rtl/tcdm_arb_pkg.sv
// rtl/tcdm_arb_pkg.sv - shared widths, helpers and request type for the TCDM port arbiter
package tcdm_arb_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    // A single requester still needs a 1-bit index so vectors stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [DEF_AW-1:0]   add;
        logic                wen;
        logic [DEF_DW/8-1:0] be;
        logic [DEF_DW-1:0]   data;
    } tcdm_req_t;

endpackage

// File: rtl/tcdm_arb_id_fifo.sv
// rtl/tcdm_arb_id_fifo.sv - in-order FIFO of requester IDs for outstanding transactions
module tcdm_arb_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDW   = 1,
    parameter int unsigned OW    = $clog2(DEPTH) + 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  logic [IDW-1:0] id_i,
    input  logic           pop_i,
    output logic [IDW-1:0] id_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [OW-1:0]  occ_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0] mem_q [DEPTH];
    logic [IDW-1:0] mem_d [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [OW-1:0]  occ_q, occ_d;

    // Explicit wrap keeps non-power-of-two-safe behaviour and pins DEPTH=1 at slot 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push_i) begin
            mem_d[wptr_q] = id_i;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop_i) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign id_o    = mem_q[rptr_q];
    assign full_o  = (occ_q == OW'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/tcdm_rr_port_arbiter.sv
// rtl/tcdm_rr_port_arbiter.sv - round-robin arbiter sharing one TCDM port with in-order response routing
module tcdm_rr_port_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NR      = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NR-1:0]             in_req,
    input  logic [NR-1:0][AW-1:0]     in_add,
    input  logic [NR-1:0]             in_wen,
    input  logic [NR-1:0][DW/8-1:0]   in_be,
    input  logic [NR-1:0][DW-1:0]     in_data,
    output logic [NR-1:0]             in_gnt,
    output logic [NR-1:0][DW-1:0]     in_r_data,
    output logic [NR-1:0]             in_r_valid,
    output logic                      out_req,
    output logic [AW-1:0]             out_add,
    output logic                      out_wen,
    output logic [DW/8-1:0]           out_be,
    output logic [DW-1:0]             out_data,
    input  logic                      out_gnt,
    input  logic [DW-1:0]             out_r_data,
    input  logic                      out_r_valid,
    output logic [$clog2(MAX_OUT):0]  outstanding_o,
    output logic                      err_o
);

    localparam int unsigned IW = idx_w(NR);
    localparam int unsigned OW = occ_w(MAX_OUT);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic          lock_q, lock_d;
    logic          err_q, err_d;
    logic [IW-1:0] sel;
    logic          found;
    logic          full, empty, push, pop;
    logic [IW-1:0] head_id;
    logic [OW-1:0] occ;

    function automatic logic [IW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        return IW'((base + off) % NR);
    endfunction

    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (!found && in_req[wrap_idx(32'(rr_ptr_q), i)]) begin
                sel   = wrap_idx(32'(rr_ptr_q), i);
                found = 1'b1;
            end
        end
        // A stalled master keeps the port until its transfer completes.
        if (lock_q) begin
            sel = lock_idx_q;
        end
    end

    // full comes from registered occupancy only, so out_r_valid never reaches out_req.
    assign out_req  = rst_ni & in_req[sel] & ~full;
    assign out_add  = in_add[sel];
    assign out_wen  = in_wen[sel];
    assign out_be   = in_be[sel];
    assign out_data = in_data[sel];
    assign push     = out_req & out_gnt;
    assign in_gnt   = push ? (NR'(1) << sel) : '0;

    assign pop        = rst_ni & out_r_valid & ~empty;
    assign in_r_valid = pop ? (NR'(1) << head_id) : '0;
    assign in_r_data  = {NR{out_r_data}};

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        if (push) begin
            rr_ptr_d = wrap_idx(32'(sel), 1);
        end else if (out_req) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
        err_d = err_q | (out_r_valid & empty);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

    tcdm_arb_id_fifo #(
        .DEPTH (MAX_OUT),
        .IDW   (IW),
        .OW    (OW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .id_i    (sel),
        .pop_i   (pop),
        .id_o    (head_id),
        .full_o  (full),
        .empty_o (empty),
        .occ_o   (occ)
    );

    assign outstanding_o = occ;
    assign err_o         = err_q;

endmodule

// File: tb/tb_tcdm_rr_port_arbiter.sv
// tb/tb_tcdm_rr_port_arbiter.sv - scoreboard bench for the round-robin TCDM port arbiter
module tb_tcdm_rr_port_arbiter;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [1:0]       in_req;
    logic [1:0][31:0] in_add;
    logic [1:0]       in_wen;
    logic [1:0][3:0]  in_be;
    logic [1:0][31:0] in_data;
    logic [1:0]       in_gnt;
    logic [1:0][31:0] in_r_data;
    logic [1:0]       in_r_valid;
    logic             out_req;
    logic [31:0]      out_add;
    logic             out_wen;
    logic [3:0]       out_be;
    logic [31:0]      out_data;
    logic             out_gnt;
    logic [31:0]      out_r_data;
    logic             out_r_valid;
    logic [2:0]       outstanding_o;
    logic             err_o;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          sb_id[$];
    logic [31:0] sb_data[$];
    logic        resp_exp = 1'b0;
    int          mon_id;
    logic [31:0] mon_data;
    logic [1:0]  mon_exp_v;

    tcdm_rr_port_arbiter #(.NR(2), .AW(32), .DW(32), .MAX_OUT(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .in_req        (in_req),
        .in_add        (in_add),
        .in_wen        (in_wen),
        .in_be         (in_be),
        .in_data       (in_data),
        .in_gnt        (in_gnt),
        .in_r_data     (in_r_data),
        .in_r_valid    (in_r_valid),
        .out_req       (out_req),
        .out_add       (out_add),
        .out_wen       (out_wen),
        .out_be        (out_be),
        .out_data      (out_data),
        .out_gnt       (out_gnt),
        .out_r_data    (out_r_data),
        .out_r_valid   (out_r_valid),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    // Response monitor: every routed response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (resp_exp || out_r_valid === 1'b1 || in_r_valid !== 2'b00) begin
            tests_run++;
            if (!resp_exp) begin
                if (in_r_valid !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL stray_rvalid: in_r_valid=%b required 00", in_r_valid);
                end
            end else if (sb_id.size() == 0 || sb_data.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_underflow: ids=%0d data=%0d required nonempty", sb_id.size(), sb_data.size());
            end else begin
                mon_id    = sb_id.pop_front();
                mon_data  = sb_data.pop_front();
                mon_exp_v = 2'b01 << mon_id;
                if (in_r_valid !== mon_exp_v || in_r_data[0] !== mon_data || in_r_data[1] !== mon_data) begin
                    tests_failed++;
                    $display("FAIL resp_route: in_r_valid=%b data0=%h data1=%h required %b/%h",
                             in_r_valid, in_r_data[0], in_r_data[1], mon_exp_v, mon_data);
                end
            end
        end
    end

    task automatic drive_resp(input logic [31:0] d, input logic exp);
        out_r_valid = 1'b1;
        out_r_data  = d;
        resp_exp    = exp;
        if (exp) sb_data.push_back(d);
    endtask

    task automatic clear_resp();
        out_r_valid = 1'b0;
        resp_exp    = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        in_req  = 2'b00;
        out_gnt = 1'b0;
        clear_resp();
        sb_id.delete();
        sb_data.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        in_req  = 2'b11;
        out_gnt = 1'b1;
        drive_resp(32'h1111_1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (in_gnt !== 2'b00 || out_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: in_gnt=%b out_req=%b required 00/0", in_gnt, out_req);
        end
        @(posedge clk); #1;
        in_req  = 2'b00;
        out_gnt = 1'b0;
        clear_resp();
        rst_ni = 1'b1;
        @(negedge clk);
        tests_run++;
        if (outstanding_o !== 3'd0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: outstanding=%0d err=%b required 0/0", outstanding_o, err_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        do_reset();
        in_req = 2'b01; in_add[0] = 32'h100; in_wen[0] = 1'b1; out_gnt = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_gnt !== 2'b01 || out_req !== 1'b1 || out_add !== 32'h100 || out_wen !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: gnt=%b req=%b add=%h wen=%b required 01/1/100/1", in_gnt, out_req, out_add, out_wen);
        end
        sb_id.push_back(0);
        @(posedge clk); #1;
        in_req = 2'b00; out_gnt = 1'b0;
        drive_resp(32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        tests_run++;
        if (in_gnt !== 2'b00 || outstanding_o !== 3'd1) begin
            tests_failed++;
            $display("FAIL single_outstanding: gnt=%b outstanding=%0d required 00/1", in_gnt, outstanding_o);
        end
        @(posedge clk); #1;
        clear_resp();
        @(negedge clk);
        tests_run++;
        if (outstanding_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL single_drain: outstanding=%0d required 0", outstanding_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alternate();
        do_reset();
        in_req = 2'b11; in_add[0] = 32'h200; in_add[1] = 32'h300; out_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (in_gnt !== (2'b01 << (c % 2)) || out_add !== ((c % 2) == 1 ? 32'h300 : 32'h200)) begin
                tests_failed++;
                $display("FAIL alternate_grant%0d: gnt=%b add=%h required %b", c, in_gnt, out_add, 2'b01 << (c % 2));
            end
            sb_id.push_back(c % 2);
            @(posedge clk); #1;
        end
        in_req = 2'b00; out_gnt = 1'b0;
        @(negedge clk);
        tests_run++;
        if (outstanding_o !== 3'd4) begin
            tests_failed++;
            $display("FAIL alternate_outstanding: outstanding=%0d required 4", outstanding_o);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            drive_resp(32'hA000 + 32'(c), 1'b1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        clear_resp();
    endtask

    task automatic test_lock();
        do_reset();
        in_req = 2'b10; in_add[0] = 32'h400; in_add[1] = 32'h500; out_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_add !== 32'h500 || in_gnt !== 2'b00 || out_req !== 1'b1) begin
                tests_failed++;
                $display("FAIL lock_hold%0d: add=%h gnt=%b req=%b required 500/00/1", c, out_add, in_gnt, out_req);
            end
            @(posedge clk); #1;
            in_req = 2'b11;
        end
        out_gnt = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_gnt !== 2'b10 || out_add !== 32'h500) begin
            tests_failed++;
            $display("FAIL lock_release: gnt=%b add=%h required 10/500", in_gnt, out_add);
        end
        sb_id.push_back(1);
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (in_gnt !== 2'b01 || out_add !== 32'h400) begin
            tests_failed++;
            $display("FAIL lock_next: gnt=%b add=%h required 01/400", in_gnt, out_add);
        end
        sb_id.push_back(0);
        @(posedge clk); #1;
        in_req = 2'b00; out_gnt = 1'b0;
        drive_resp(32'hB1, 1'b1);
        @(posedge clk); #1;
        drive_resp(32'hB0, 1'b1);
        @(posedge clk); #1;
        clear_resp();
    endtask

    task automatic test_full();
        int grants;
        grants = 0;
        do_reset();
        in_req = 2'b01; in_add[0] = 32'h600; out_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_gnt === 2'b01) grants++;
            if (c >= 4) begin
                tests_run++;
                if (out_req !== 1'b0 || outstanding_o !== 3'd4) begin
                    tests_failed++;
                    $display("FAIL full_block%0d: req=%b outstanding=%0d required 0/4", c, out_req, outstanding_o);
                end
            end else begin
                sb_id.push_back(0);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (grants != 4) begin
            tests_failed++;
            $display("FAIL full_grants: grants=%0d required 4", grants);
        end
        drive_resp(32'hC0, 1'b1);
        @(negedge clk);
        tests_run++;
        if (in_gnt !== 2'b00 || out_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_same_cycle: gnt=%b req=%b required 00/0", in_gnt, out_req);
        end
        @(posedge clk); #1;
        clear_resp();
        @(negedge clk);
        tests_run++;
        if (in_gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL full_resume: gnt=%b required 01", in_gnt);
        end
        sb_id.push_back(0);
        @(posedge clk); #1;
        in_req = 2'b00; out_gnt = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            drive_resp(32'hC0 + 32'(c), 1'b1);
            @(posedge clk); #1;
        end
        clear_resp();
        @(negedge clk);
        tests_run++;
        if (outstanding_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL full_drain: outstanding=%0d required 0", outstanding_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_err();
        do_reset();
        drive_resp(32'hBAD, 1'b0);
        @(negedge clk);
        tests_run++;
        if (err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_registered: err=%b required 0", err_o);
        end
        @(posedge clk); #1;
        clear_resp();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (err_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL err_sticky%0d: err=%b required 1", c, err_o);
            end
            @(posedge clk); #1;
        end
        do_reset();
        @(negedge clk);
        tests_run++;
        if (err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: err=%b required 0", err_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_req = 2'b01; in_add[0] = 32'h700; in_add[1] = 32'h800; out_gnt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (in_gnt !== 2'b01) begin
                tests_failed++;
                $display("FAIL mid_pre_grant%0d: gnt=%b required 01", c, in_gnt);
            end
            @(posedge clk); #1;
        end
        in_req = 2'b00; out_gnt = 1'b0;
        @(negedge clk);
        tests_run++;
        if (outstanding_o !== 3'd2) begin
            tests_failed++;
            $display("FAIL mid_outstanding: outstanding=%0d required 2", outstanding_o);
        end
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        tests_run++;
        if (outstanding_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL mid_flushed: outstanding=%0d required 0", outstanding_o);
        end
        @(posedge clk); #1;
        drive_resp(32'h5A1E, 1'b0);
        @(posedge clk); #1;
        clear_resp();
        @(negedge clk);
        tests_run++;
        if (err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_stale_err: err=%b required 1", err_o);
        end
        @(posedge clk); #1;
        in_req = 2'b11; out_gnt = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_gnt !== 2'b01 || out_add !== 32'h700) begin
            tests_failed++;
            $display("FAIL mid_first_grant: gnt=%b add=%h required 01/700", in_gnt, out_add);
        end
        sb_id.push_back(0);
        @(posedge clk); #1;
        in_req = 2'b00; out_gnt = 1'b0;
        drive_resp(32'hD0, 1'b1);
        @(posedge clk); #1;
        clear_resp();
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_req      = 2'b00;
        in_add      = '0;
        in_wen      = 2'b11;
        in_be       = '1;
        in_data     = '0;
        out_gnt     = 1'b0;
        out_r_data  = '0;
        out_r_valid = 1'b0;
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_full();
        test_err();
        test_reset_mid();
        @(negedge clk);
        tests_run++;
        if (sb_id.size() != 0 || sb_data.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: ids=%0d data=%0d required 0/0", sb_id.size(), sb_data.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tcdm_rr_port_arbiter.md
Name: tcdm_rr_port_arbiter

Overview:
- Shares one single-port TCDM/memory target between NR requesters, e.g. the core data port and the HWPE master ports, replacing ad-hoc address/rvalid muxing.
- Round-robin arbitration of requests; tracks outstanding transactions in an in-order ID FIFO, so each response returns only to the requester that issued it.
- Sits between the masters and the memory model or interconnect in the simulation top and in the SoC.

Parameters:
NR, 2, number of requesters (>=2)
AW, 32, address width
DW, 32, data width
MAX_OUT, 4, maximum outstanding transactions (power of 2, >=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous and active-low
in_req  in  NR  request per requester
in_add  in  NRxAW  address
in_wen  in  NR  1=read, 0=write
in_be  in  NRx(DW/8)  byte enables
in_data  in  NRxDW  write data
in_gnt  out  NR  grant per requester
in_r_data  out  NRxDW  response data (broadcast of out_r_data)
in_r_valid  out  NR  response valid per requester
out_req  out  1  target request
out_add  out  AW  target address
out_wen  out  1  target wen
out_be  out  DW/8  target byte enables
out_data  out  DW  target write data
out_gnt  in  1  target grant
out_r_data  in  DW  target response data
out_r_valid  in  1  target response valid (in order, >=1 cycle after grant)
outstanding_o  out  clog2(MAX_OUT)+1  current FIFO occupancy
err_o  out  1  sticky error: response received with no outstanding transaction

Behaviour:
- Reset, sampled at clk_i rising edge while rst_ni=0:
  - rr pointer=0; lock=0; FIFO empty; outstanding_o=0; err_o=0.
  - Outputs during reset: in_gnt=0, in_r_valid=0, out_req=0.
- Arbitration (combinational select, registered state):
  - sel = first requesting index at or after rr_ptr, wrapping modulo NR.
  - If lock=1, sel = locked index.
  - out_req = in_req[sel] & ~full. out_add/wen/be/data = in_*[sel].
  - in_gnt[sel] = out_gnt & out_req; all other in_gnt=0.
- Handshake: a transfer occurs in a cycle where out_req & out_gnt = 1.
  - On transfer: push sel into the FIFO; rr_ptr <= (sel+1) mod NR; lock <= 0.
  - If out_req=1 and out_gnt=0: lock <= 1, lock_idx <= sel. Selection is held until the transfer, so a stalled master's request is never preempted.
  - If the locked requester drops in_req (protocol violation): lock clears next cycle, and no grant is issued to it.
- Full: full = (occupancy == MAX_OUT).
  - When full, out_req=0 and no grant is issued, even if a response pops in the same cycle.
  - Arbitration resumes the cycle after occupancy drops.
- Response: when out_r_valid=1 and the FIFO is non-empty:
  - in_r_valid[head] = 1 combinationally (zero added latency); pop the head.
  - in_r_data for all requesters = out_r_data.
- Empty FIFO with out_r_valid=1: response dropped, all in_r_valid=0, err_o <= 1 (sticky until reset).
- Same-cycle push and pop: occupancy unchanged; pointers both advance.
  - With MAX_OUT=1, this is allowed only when not full at cycle start.
- occupancy: +1 on push, -1 on pop; wrap of read/write pointers modulo MAX_OUT.
- Reset mid-operation: all outstanding state is discarded. Responses arriving after reset set err_o, per the empty-FIFO rule.
- No combinational path from out_r_valid to out_req other than via registered occupancy.

Decomposition:
- Package tcdm_arb_pkg: requester-index width function/localparam, occupancy width, and a request struct (add, wen, be, data) parameterised via localparams for the default AW/DW.
- One sub-module, tcdm_arb_id_fifo: synchronous FIFO of clog2(NR)-bit IDs, depth MAX_OUT, with push/pop/full/empty/occupancy.
- The round-robin selector stays inline.

Test Plan:
- Single requester 0 reads addr 0x100, out_gnt=1, response 1 cycle later with 0xDEADBEEF -> in_gnt[0]=1 for 1 cycle; in_r_valid[0]=1 with 0xDEADBEEF; in_r_valid[1]=0; outstanding_o 1 then 0.
- Both requesters held high, out_gnt=1 always, NR=2 -> grants alternate 0,1,0,1 over 4 cycles; responses routed in the same order.
- Requester 1 selected, out_gnt=0 for 3 cycles while requester 0 also requests -> out_add stays requester 1's address for all 3 cycles; requester 1 is granted on cycle 4, then requester 0.
- MAX_OUT=4, out_gnt=1, no responses for 6 cycles -> exactly 4 grants; out_req=0 once outstanding_o=4. One response -> a grant resumes on the next cycle, not the same cycle.
- out_r_valid=1 while empty after reset -> no in_r_valid; err_o=1 and stays 1 until rst_ni=0.
- Reset asserted with 2 outstanding -> next cycle outstanding_o=0, rr_ptr=0, and the first grant after reset goes to requester 0.
